muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit, parametrised in XLEN.
- Executes all eight M-extension ops, selected by funct3, alongside the combinational ALU.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while it works.
- Shift-add multiply and restoring divide; one bit is processed per cycle.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- flush  input  1  abort the current operation; no done pulse follows.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  XLEN  rs1 operand (dividend / multiplicand).
- src_b  input  XLEN  rs2 operand (divisor / multiplier).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  result register; holds its value until the next done.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
  - Reset asserted mid-operation discards that operation.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 latches funct3, the operand magnitudes and the sign-fix flags, and loads counter=XLEN.
  - funct3[2]=0 goes to MUL; funct3[2]=1 goes to DIV.
  - Divide-by-zero and signed overflow skip DIV and go straight to FIN.
- Operand signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats src_a as signed and src_b as unsigned.
  - MULHU, DIVU, REMU and MUL treat both as unsigned; the low half is sign-independent.
  - Signed operands are converted to magnitude on entry; the sign is fixed in FIN.
- MUL:
  - Per cycle: if multiplier LSB=1, add multiplicand to the upper half of a 2*XLEN accumulator.
  - Then shift the accumulator right 1, carry included, and decrement the counter.
  - Exactly XLEN cycles, then FIN.
- DIV (restoring):
  - Per cycle: shift {rem,quot} left 1.
  - Trial-subtract the divisor (an XLEN+1-bit compare).
  - If the result is non-negative, commit it and set the quotient LSB.
  - Exactly XLEN cycles, then FIN.
- FIN (one cycle):
  - Apply sign fix: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign.
  - Select the result: MUL gives the low XLEN; MULH/MULHSU/MULHU give the high XLEN; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register result, assert done=1 for exactly this cycle, then return to IDLE.
- Latency:
  - start accepted at edge N gives done high in cycle N+XLEN+1 (33 cycles for XLEN=32).
  - Fast paths give done high in cycle N+1.
- Special cases (RISC-V spec):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give src_a.
  - DIV overflow (src_a = most negative, src_b = -1, signed): quotient = src_a, remainder = 0.
- busy=1 in MUL, DIV and FIN; busy=0 in IDLE.
- start while busy is ignored; the operation in flight is unaffected.
- flush:
  - Forces IDLE on the next edge from any state; done is not asserted and result is unchanged.
  - flush has priority over start in the same cycle (start is dropped).
  - flush with start in IDLE also drops the start.
- Back-to-back: start may be asserted in the cycle after done, i.e. in IDLE.

Test Plan:
- MUL with XLEN=32, a=7, b=-3 (0xFFFFFFFD) -> done exactly 33 cycles after start, result=0xFFFFFFEB; busy high for cycles 1..33.
- MULH / MULHSU / MULHU with a=0x80000000, b=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- Divide by zero, DIVU a=5, b=0 -> 0xFFFFFFFF with done one cycle after start; REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000, one-cycle latency.
- flush at cycle 10 of a DIV -> idle next cycle, no done pulse, result keeps its prior value. start held during busy -> exactly one done.
- reset_n pulled low mid-MUL, asynchronously -> busy, done and result are 0 immediately. After release, a new MUL completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
// Shift-add multiply and restoring divide share a single 2*XLEN accumulator.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_next_s;
    logic [1:0]        op_sel_r;
    logic              a_neg_r, b_neg_r;
    logic [XLEN-1:0]   op_r;
    logic [2*XLEN-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r;
    logic [XLEN-1:0]   result_r;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic              div_zero_s, div_ovf_s;
    logic              load_s, step_s, last_s;
    logic [XLEN:0]     mul_sum_s, rem_sh_s;
    logic [2*XLEN-1:0] mul_nxt_s, prod_s, div_nxt_s;
    logic [XLEN-1:0]   div_diff_s, quot_s, rem_s;
    logic [XLEN-1:0]   fast_res_s, fin_res_s, res_next_s;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Operand signedness and the divide corner cases that bypass iteration
    always_comb begin
        a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_s    = a_signed_s && src_a[XLEN-1];
        b_neg_s    = b_signed_s && src_b[XLEN-1];
        div_zero_s = funct3[2] && (src_b == {XLEN{1'b0}});
        div_ovf_s  = funct3[2] && !funct3[0] &&
                     (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == {XLEN{1'b1}});
        if (div_zero_s) begin
            fast_res_s = funct3[1] ? src_a : {XLEN{1'b1}};
        end else begin
            fast_res_s = funct3[1] ? {XLEN{1'b0}} : src_a;
        end
    end

    // One iteration of each algorithm plus the sign-fixed final result
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, op_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        end
        mul_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        prod_s    = (a_neg_r ^ b_neg_r) ? -mul_nxt_s : mul_nxt_s;

        // Remainder shifted left with the next dividend bit; compared at XLEN+1 bits
        rem_sh_s   = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s = rem_sh_s[XLEN-1:0] - op_r;
        if (rem_sh_s >= {1'b0, op_r}) begin
            div_nxt_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_nxt_s = {acc_r[2*XLEN-2:0], 1'b0};
        end
        quot_s = (a_neg_r ^ b_neg_r) ? -div_nxt_s[XLEN-1:0] : div_nxt_s[XLEN-1:0];
        rem_s  = a_neg_r ? -div_nxt_s[2*XLEN-1:XLEN] : div_nxt_s[2*XLEN-1:XLEN];

        if (state_r == MUL) begin
            fin_res_s = (op_sel_r == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else begin
            fin_res_s = op_sel_r[1] ? rem_s : quot_s;
        end
        if (state_r == IDLE) begin
            res_next_s = fast_res_s;
        end else begin
            res_next_s = fin_res_s;
        end
    end

    // Next-state logic; the result is captured on the edge into FIN so done and result coincide
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = (cnt_r == CNT_ONE);
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (start) begin
                    load_s = 1'b1;
                    if (div_zero_s || div_ovf_s) begin
                        state_next_s = FIN;
                    end else if (funct3[2]) begin
                        state_next_s = DIV;
                    end else begin
                        state_next_s = MUL;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (last_s) begin
                        state_next_s = FIN;
                    end else begin
                        state_next_s = state_r;
                    end
                end
            end
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch and iterative accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_sel_r <= 2'b00;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            op_r     <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (load_s) begin
            op_sel_r <= funct3[1:0];
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            cnt_r    <= CNT_LOAD;
            if (funct3[2]) begin
                op_r  <= magnitude(src_b, b_neg_s);
                acc_r <= {{XLEN{1'b0}}, magnitude(src_a, a_neg_s)};
            end else begin
                op_r  <= magnitude(src_a, a_neg_s);
                acc_r <= {{XLEN{1'b0}}, magnitude(src_b, b_neg_s)};
            end
        end else if (step_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            acc_r <= (state_r == MUL) ? mul_nxt_s : div_nxt_s;
        end
    end

    // Registered handshake outputs and result hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == FIN);
            if (state_next_s == FIN) begin
                result_r <= res_next_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule
